rst_seq_ctrl: RTL and testbench
===============================

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (legal range 2..8).
REQ-002 SHALL have parameter STRETCH_CYCLES, default 16, reset hold cycles after synchronizer release (legal range >=1).
REQ-003 SHALL have parameter NUM_RST, default 4, number of sequenced reset outputs (legal range 1..16).
REQ-004 SHALL have parameter SEQ_GAP, default 4, cycles between consecutive output releases (legal range >=1).
REQ-005 SHALL have port clk, input, 1, system clock; all logic is on rising edge.
REQ-006 SHALL have port arst_i, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port swrst_i, input, 1, software reset request, synchronous to clk, active-high level.
REQ-008 SHALL have port srst_o, output, NUM_RST, per-domain synchronous resets, active-high, registered.
REQ-009 SHALL have port rst_done_o, output, 1, high when all srst_o bits are released.
REQ-010 SHALL have port rst_cause_o, output, 2, last reset cause (see Configuration).

Function
REQ-011 SHALL use a SYNC_STAGES-deep flop chain, set asynchronously to all-ones by arst_i and shifting in 0; its last stage is internal signal rst_int.
REQ-012 SHALL implement FSM states SYNC, STRETCH, SEQ, RUN; SYNC while rst_int=1; SYNC->STRETCH on the edge where rst_int falls.
REQ-013 Edge numbering: edge 1 is the first rising clk edge with arst_i low; rst_int SHALL be low after edge SYNC_STAGES.
REQ-014 STRETCH SHALL count STRETCH_CYCLES edges; srst_o[0] SHALL go low after edge SYNC_STAGES+STRETCH_CYCLES and FSM SHALL enter SEQ (or RUN if NUM_RST=1).
REQ-015 srst_o[k] SHALL go low after edge SYNC_STAGES+STRETCH_CYCLES+k*SEQ_GAP, for k=1..NUM_RST-1; bits release strictly in ascending index order.
REQ-016 FSM SHALL enter RUN on the same edge srst_o[NUM_RST-1] goes low; rst_done_o SHALL be high exactly in RUN.
REQ-017 swrst_i sampled high in STRETCH, SEQ or RUN SHALL set all srst_o bits high and rst_done_o low after that edge, and SHALL move FSM to STRETCH with counter cleared.
REQ-018 While swrst_i stays high, the STRETCH counter SHALL be held at 0; counting resumes on the first edge with swrst_i low, and release timing follows REQ-014/015 measured from that edge.
REQ-019 swrst_i SHALL be ignored in SYNC.
REQ-020 Once released, a srst_o bit SHALL NOT reassert except via arst_i or swrst_i.

Reset
REQ-021 arst_i high SHALL asynchronously set the sync chain to all-ones, srst_o to all-ones, rst_done_o to 0, FSM to SYNC and counters to 0.
REQ-022 arst_i asserted mid-STRETCH, mid-SEQ or in RUN SHALL abort the sequence immediately; the full sequence restarts from edge 1 after deassertion.
REQ-023 Deassertion of arst_i SHALL never change any output without a clk edge.

Configuration
REQ-024 Macro RST_SEQ_CTRL_CAUSE_EN SHALL compile in a reset-cause register.
REQ-025 With the macro, rst_cause_o SHALL be set asynchronously to 2'b01 by arst_i and to 2'b10 on the edge a swrst_i request is accepted (REQ-017), holding otherwise.
REQ-026 Without the macro, rst_cause_o SHALL be constant 2'b00 and no cause register exists.

Verification
REQ-027 Defaults, arst_i pulse then low -> srst_o[0] low after edge 18, srst_o[1..3] low after edges 22/26/30, rst_done_o high after edge 30.
REQ-028 NUM_RST=1, SYNC_STAGES=3, STRETCH_CYCLES=1 -> srst_o low and rst_done_o high after edge 4.
REQ-029 Defaults in RUN, swrst_i high 3 cycles -> srst_o=4'hF and rst_done_o=0 after first sampled edge; srst_o[0] low 16 edges after swrst_i first sampled low.
REQ-030 Defaults, arst_i asserted between srst_o[1] and srst_o[2] releases -> srst_o=4'hF immediately without clk edge; full sequence repeats from edge 1.
REQ-031 Macro defined: arst_i -> rst_cause_o=2'b01; later accepted swrst_i -> 2'b10; swrst_i during SYNC -> no change. Macro undefined -> rst_cause_o=2'b00 throughout.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronizes arst_i, stretches it, then releases srst_o bits one by one in ascending order.
// Optional reset-cause register is compiled in with RST_SEQ_CTRL_CAUSE_EN.
module rst_seq_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int NUM_RST        = 4,
    parameter int SEQ_GAP        = 4
) (
    input  logic               clk,
    input  logic               arst_i,
    input  logic               swrst_i,
    output logic [NUM_RST-1:0] srst_o,
    output logic               rst_done_o,
    output logic [1:0]         rst_cause_o
);

    localparam int MAX_CNT = (STRETCH_CYCLES > SEQ_GAP) ? STRETCH_CYCLES : SEQ_GAP;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(SEQ_GAP - 1);

    typedef enum logic [1:0] {SYNC, STRETCH, SEQ, RUN} state_e;

    state_e               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_RST-1:0]   srst_q, srst_d;
    logic                 done_q, done_d;
    logic                 rst_int;
    logic                 swrst_accept;

    assign rst_int      = sync_q[SYNC_STAGES-1];
    assign swrst_accept = swrst_i && (state_q != SYNC);

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b0};
        state_d = state_q;
        cnt_d   = cnt_q;
        srst_d  = srst_q;
        case (state_q)
            // Leave SYNC on the edge that shifts the last 1 out of the chain.
            SYNC: begin
                if (rst_int && !sync_q[SYNC_STAGES-2]) begin
                    state_d = STRETCH;
                    cnt_d   = '0;
                end
            end
            STRETCH: begin
                if (cnt_q == STRETCH_LAST) begin
                    srst_d  = srst_q << 1;
                    cnt_d   = '0;
                    state_d = (NUM_RST == 1) ? RUN : SEQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEQ: begin
                if (cnt_q == GAP_LAST) begin
                    srst_d = srst_q << 1;
                    cnt_d  = '0;
                    if ((srst_q << 1) == '0) begin
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // A held software request keeps the stretch counter parked at zero.
        if (swrst_accept) begin
            state_d = STRETCH;
            cnt_d   = '0;
            srst_d  = '1;
        end
        done_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            sync_q  <= '1;
            state_q <= SYNC;
            cnt_q   <= '0;
            srst_q  <= '1;
            done_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            srst_q  <= srst_d;
            done_q  <= done_d;
        end
    end

    assign srst_o     = srst_q;
    assign rst_done_o = done_q;

`ifdef RST_SEQ_CTRL_CAUSE_EN
    logic [1:0] cause_q, cause_d;

    always_comb begin
        cause_d = swrst_accept ? 2'b10 : cause_q;
    end

    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            cause_q <= 2'b01;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign rst_cause_o = cause_q;
`else
    assign rst_cause_o = 2'b00;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: fixed release tables, hand-written corner sequences, then random stimulus vs. a release-time model.
module tb_rst_seq_ctrl;

`ifdef RST_SEQ_CTRL_CAUSE_EN
    localparam logic [1:0] CAUSE_HW = 2'b01;
    localparam logic [1:0] CAUSE_SW = 2'b10;
`else
    localparam logic [1:0] CAUSE_HW = 2'b00;
    localparam logic [1:0] CAUSE_SW = 2'b00;
`endif

    logic       clk = 1'b0;
    logic       arst_i;
    logic       swrst_i;
    logic [3:0] srst_a;
    logic       done_a;
    logic [1:0] cause_a;
    logic [0:0] srst_b;
    logic       done_b;
    logic [1:0] cause_b;

    always #5 clk = ~clk;

    rst_seq_ctrl #(.SYNC_STAGES(2), .STRETCH_CYCLES(16), .NUM_RST(4), .SEQ_GAP(4)) dut_a (
        .clk(clk), .arst_i(arst_i), .swrst_i(swrst_i),
        .srst_o(srst_a), .rst_done_o(done_a), .rst_cause_o(cause_a)
    );

    rst_seq_ctrl #(.SYNC_STAGES(3), .STRETCH_CYCLES(1), .NUM_RST(1), .SEQ_GAP(4)) dut_b (
        .clk(clk), .arst_i(arst_i), .swrst_i(swrst_i),
        .srst_o(srst_b), .rst_done_o(done_b), .rst_cause_o(cause_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_c counts edges since arst release; bit k is released once m_c >= m_b + k*gap.
    int         m_s[2]   = '{2, 3};
    int         m_st[2]  = '{16, 1};
    int         m_n[2]   = '{4, 1};
    int         m_gap[2] = '{4, 4};
    int         m_c[2];
    int         m_b[2];
    logic [1:0] m_cause[2];

    function automatic void model_arst();
        for (int i = 0; i < 2; i++) begin
            m_c[i]     = 0;
            m_b[i]     = m_s[i] + m_st[i];
            m_cause[i] = CAUSE_HW;
        end
    endfunction

    function automatic void model_edge();
        if (!arst_i) begin
            for (int i = 0; i < 2; i++) begin
                int prev;
                prev   = m_c[i];
                m_c[i] = m_c[i] + 1;
                if (swrst_i && prev >= m_s[i]) begin
                    m_b[i]     = m_c[i] + m_st[i];
                    m_cause[i] = CAUSE_SW;
                end
            end
        end
    endfunction

    function automatic logic [15:0] exp_srst(input int i);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < m_n[i]; k++) r[k] = (m_c[i] < m_b[i] + k * m_gap[i]);
        return r;
    endfunction

    function automatic logic exp_done(input int i);
        return m_c[i] >= m_b[i] + (m_n[i] - 1) * m_gap[i];
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_srst_a"},  {12'b0, srst_a},  exp_srst(0));
        chk({tag, "_done_a"},  {15'b0, done_a},  {15'b0, exp_done(0)});
        chk({tag, "_cause_a"}, {14'b0, cause_a}, {14'b0, m_cause[0]});
        chk({tag, "_srst_b"},  {15'b0, srst_b},  exp_srst(1));
        chk({tag, "_done_b"},  {15'b0, done_b},  {15'b0, exp_done(1)});
        chk({tag, "_cause_b"}, {14'b0, cause_b}, {14'b0, m_cause[1]});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        int         edge_n;
        logic [3:0] sa;
        logic       da;
        logic       sb;
        logic       db;
    } vec_t;

    vec_t vt[13];
    int   ecnt;
    int   hold;

    initial begin
        vt[0]  = '{1,  4'hF, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{2,  4'hF, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{3,  4'hF, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{4,  4'hF, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{17, 4'hF, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{18, 4'hE, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{21, 4'hE, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{22, 4'hC, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{25, 4'hC, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{26, 4'h8, 1'b0, 1'b0, 1'b1};
        vt[10] = '{29, 4'h8, 1'b0, 1'b0, 1'b1};
        vt[11] = '{30, 4'h0, 1'b1, 1'b0, 1'b1};
        vt[12] = '{31, 4'h0, 1'b1, 1'b0, 1'b1};

        arst_i  = 1'b1;
        swrst_i = 1'b0;
        hold    = 0;
        model_arst();
        #12;
        chk("reset_srst_a",  {12'b0, srst_a},  16'hF);
        chk("reset_done_a",  {15'b0, done_a},  16'h0);
        chk("reset_cause_a", {14'b0, cause_a}, {14'b0, CAUSE_HW});
        chk("reset_srst_b",  {15'b0, srst_b},  16'h1);
        arst_i = 1'b0;
        #1;
        check_model("release_no_edge");

        // Release timing after a plain arst pulse.
        ecnt = 0;
        for (int v = 0; v < 13; v++) begin
            while (ecnt < vt[v].edge_n) begin
                tick();
                ecnt++;
            end
            chk("tbl_srst_a", {12'b0, srst_a}, {12'b0, vt[v].sa});
            chk("tbl_done_a", {15'b0, done_a}, {15'b0, vt[v].da});
            chk("tbl_srst_b", {15'b0, srst_b}, {15'b0, vt[v].sb});
            chk("tbl_done_b", {15'b0, done_b}, {15'b0, vt[v].db});
        end

        // Software reset from RUN, held three cycles.
        swrst_i = 1'b1;
        tick();
        chk("sw_first_srst_a",  {12'b0, srst_a},  16'hF);
        chk("sw_first_done_a",  {15'b0, done_a},  16'h0);
        chk("sw_first_cause_a", {14'b0, cause_a}, {14'b0, CAUSE_SW});
        tick();
        tick();
        swrst_i = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("sw_15_srst_a", {12'b0, srst_a}, 16'hF);
        tick();
        chk("sw_16_srst_a", {12'b0, srst_a}, 16'hE);
        for (int i = 0; i < 6; i++) tick();
        chk("sw_22_srst_a", {12'b0, srst_a}, 16'hC);

        // arst between the srst_o[1] and srst_o[2] releases.
        arst_i = 1'b1;
        model_arst();
        #1;
        chk("abort_async_srst_a", {12'b0, srst_a},  16'hF);
        chk("abort_async_done_a", {15'b0, done_a},  16'h0);
        chk("abort_cause_a",      {14'b0, cause_a}, {14'b0, CAUSE_HW});
        tick();
        chk("abort_held_srst_a", {12'b0, srst_a}, 16'hF);
        arst_i = 1'b0;
        #1;
        chk("abort_release_srst_a", {12'b0, srst_a}, 16'hF);

        // swrst_i during SYNC is ignored.
        swrst_i = 1'b1;
        tick();
        tick();
        swrst_i = 1'b0;
        chk("sync_sw_cause_a", {14'b0, cause_a}, {14'b0, CAUSE_HW});
        chk("sync_sw_cause_b", {14'b0, cause_b}, {14'b0, CAUSE_HW});
        ecnt = 2;
        while (ecnt < 17) begin tick(); ecnt++; end
        chk("restart_17_srst_a", {12'b0, srst_a}, 16'hF);
        chk("restart_17_srst_b", {15'b0, srst_b}, 16'h0);
        tick();
        chk("restart_18_srst_a", {12'b0, srst_a}, 16'hE);
        while (ecnt < 29) begin tick(); ecnt++; end
        chk("restart_30_srst_a", {12'b0, srst_a}, 16'h0);
        chk("restart_30_done_a", {15'b0, done_a}, 16'h1);
        check_model("post_hand");

        // Random swrst bursts and occasional async arst pulses.
        for (int n = 0; n < 3000; n++) begin
            if (hold > 0) begin
                swrst_i = 1'b1;
                hold--;
            end else if ($urandom_range(0, 79) == 0) begin
                swrst_i = 1'b1;
                hold    = $urandom_range(0, 3);
            end else begin
                swrst_i = 1'b0;
            end
            if ($urandom_range(0, 399) == 0) begin
                arst_i = 1'b1;
                model_arst();
                #1;
                check_model("rand_arst");
                #2;
                arst_i = 1'b0;
                #1;
                check_model("rand_arst_release");
            end
            tick();
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
